// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the two-port SRAM arbiter.
package sram_arb_pkg;

    // Requester identifiers, also used as priority-pointer values.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // One entry of the read-response tag pipe: a read is in flight for `port`.
    typedef struct packed {
        logic vld;
        logic port;
    } rd_tag_t;

    // Round-robin update: after any grant the other port gets priority.
    function automatic logic next_prio(input logic granted,
                                       input logic gnt_port,
                                       input logic cur_prio);
        logic nxt;
        nxt = cur_prio;
        if (granted) begin
            nxt = ~gnt_port;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sram_arb_resp_pipe.sv
// Fixed-length delay line of read tags, matching the wrapper+macro read latency.
// READ_LATENCY must be at least 1.
module sram_arb_resp_pipe
    import sram_arb_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic    clock,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage_q [READ_LATENCY];

    // Shift tags one stage per cycle; reset drops every in-flight read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // The last stage lines up with the cycle in which sram_dout holds the read data.
    assign tag_out = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/sram_arbiter_sky130.sv
// Two-requester round-robin arbiter and sequencer for one single-port sky130 SRAM wrapper.
// One access is issued per cycle; read data is routed back to the issuing requester
// after the fixed READ_LATENCY, in issue order.
module sram_arbiter_sky130
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned WMASK_WIDTH  = 4,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                   clock,
    input  logic                   reset,

    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic                   req0_we,
    input  logic [WMASK_WIDTH-1:0] req0_wmask,
    input  logic [ADDR_WIDTH-1:0]  req0_addr,
    input  logic [DATA_WIDTH-1:0]  req0_wdata,
    output logic                   resp0_valid,
    output logic [DATA_WIDTH-1:0]  resp0_rdata,

    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic                   req1_we,
    input  logic [WMASK_WIDTH-1:0] req1_wmask,
    input  logic [ADDR_WIDTH-1:0]  req1_addr,
    input  logic [DATA_WIDTH-1:0]  req1_wdata,
    output logic                   resp1_valid,
    output logic [DATA_WIDTH-1:0]  resp1_rdata,

    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    logic    prio_q;
    logic    gnt0;
    logic    gnt1;
    rd_tag_t tag_in;
    rd_tag_t tag_out;

    // Grant: a lone requester wins; on contention the priority pointer decides.
    // Nothing is granted while reset is high.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0_valid && (!req1_valid || (prio_q == PORT0))) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Priority pointer flips to the other port after every grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_q <= PORT0;
        end else begin
            prio_q <= next_prio(gnt0 | gnt1, gnt1, prio_q);
        end
    end

    // Drive the granted request onto the wrapper port; all zero when idle.
    always_comb begin
        sram_we    = 1'b0;
        sram_wmask = '0;
        sram_addr  = '0;
        sram_din   = '0;
        if (gnt0) begin
            sram_we    = req0_we;
            sram_wmask = req0_wmask;
            sram_addr  = req0_addr;
            sram_din   = req0_wdata;
        end else if (gnt1) begin
            sram_we    = req1_we;
            sram_wmask = req1_wmask;
            sram_addr  = req1_addr;
            sram_din   = req1_wdata;
        end
    end

    // Tag each issued read with its port; writes and idle cycles push an empty tag.
    always_comb begin
        tag_in.vld  = (gnt0 && !req0_we) || (gnt1 && !req1_we);
        tag_in.port = gnt1 ? PORT1 : PORT0;
    end

    sram_arb_resp_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_resp_pipe (
        .clock   (clock),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Route returning read data to the tagged port; rdata is zeroed when not valid.
    always_comb begin
        resp0_valid = tag_out.vld && (tag_out.port == PORT0);
        resp1_valid = tag_out.vld && (tag_out.port == PORT1);
        resp0_rdata = resp0_valid ? sram_dout : '0;
        resp1_rdata = resp1_valid ? sram_dout : '0;
    end

endmodule

// File: tb/tb_sram_arbiter_sky130.sv
// Directed bench for sram_arbiter_sky130 with a behavioural single-port SRAM model.
`ifndef CLOCK_PERIOD
`define CLOCK_PERIOD 10
`endif

module tb_sram_arbiter_sky130;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 32;
    localparam int unsigned MW  = 4;
    localparam int unsigned LAT = 2;

    typedef struct packed {
        logic          v;
        logic          we;
        logic [MW-1:0] m;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    typedef struct packed {
        logic          rdy0;
        logic          rdy1;
        logic          swe;
        logic [MW-1:0] smask;
        logic [AW-1:0] saddr;
        logic [DW-1:0] sdin;
        logic          rv0;
        logic [DW-1:0] rd0;
        logic          rv1;
        logic [DW-1:0] rd1;
    } out_t;

    typedef struct {
        req_t r0;
        req_t r1;
        out_t e;
    } vec_t;

    logic          clock;
    logic          reset;
    logic          req0_valid, req0_ready, req0_we;
    logic [MW-1:0] req0_wmask;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          resp0_valid;
    logic [DW-1:0] resp0_rdata;
    logic          req1_valid, req1_ready, req1_we;
    logic [MW-1:0] req1_wmask;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          resp1_valid;
    logic [DW-1:0] resp1_rdata;
    logic          sram_we;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    int n_total = 0;
    int n_pass  = 0;
    vec_t vecs[$];

    sram_arbiter_sky130 #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .WMASK_WIDTH  (MW),
        .READ_LATENCY (LAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_we     (req0_we),
        .req0_wmask  (req0_wmask),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .resp0_valid (resp0_valid),
        .resp0_rdata (resp0_rdata),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_we     (req1_we),
        .req1_wmask  (req1_wmask),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .resp1_valid (resp1_valid),
        .resp1_rdata (resp1_rdata),
        .sram_we     (sram_we),
        .sram_wmask  (sram_wmask),
        .sram_addr   (sram_addr),
        .sram_din    (sram_din),
        .sram_dout   (sram_dout)
    );

    initial clock = 1'b0;
    always #(`CLOCK_PERIOD / 2) clock = ~clock;

    // Behavioural SRAM wrapper: byte-lane masked write, LAT-cycle read pipe.
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] dpipe [LAT];

    always @(posedge clock) begin
        if (sram_we) begin
            for (int l = 0; l < int'(MW); l++) begin
                if (sram_wmask[l]) mem[sram_addr][8*l +: 8] <= sram_din[8*l +: 8];
            end
        end
        dpipe[0] <= mem[sram_addr];
        for (int i = 1; i < int'(LAT); i++) dpipe[i] <= dpipe[i-1];
    end
    assign sram_dout = dpipe[LAT-1];

    function automatic logic [DW-1:0] mv(input int i);
        return 32'hA000_0000 + i;
    endfunction

    function automatic req_t rd_req(input logic [AW-1:0] a);
        return '{v: 1'b1, we: 1'b0, m: '0, a: a, d: '0};
    endfunction

    function automatic req_t wr_req(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                    input logic [MW-1:0] m);
        return '{v: 1'b1, we: 1'b1, m: m, a: a, d: d};
    endfunction

    function automatic req_t no_req();
        return '0;
    endfunction

    function automatic out_t exp_out(input logic r0, input logic r1, input logic we,
                                     input logic [MW-1:0] m, input logic [AW-1:0] a,
                                     input logic [DW-1:0] din, input logic v0,
                                     input logic [DW-1:0] d0, input logic v1,
                                     input logic [DW-1:0] d1);
        return '{rdy0: r0, rdy1: r1, swe: we, smask: m, saddr: a, sdin: din,
                 rv0: v0, rd0: d0, rv1: v1, rd1: d1};
    endfunction

    function automatic out_t sample();
        return '{rdy0: req0_ready, rdy1: req1_ready, swe: sram_we, smask: sram_wmask,
                 saddr: sram_addr, sdin: sram_din, rv0: resp0_valid, rd0: resp0_rdata,
                 rv1: resp1_valid, rd1: resp1_rdata};
    endfunction

    task automatic drive(input req_t a, input req_t b);
        req0_valid = a.v; req0_we = a.we; req0_wmask = a.m; req0_addr = a.a; req0_wdata = a.d;
        req1_valid = b.v; req1_we = b.we; req1_wmask = b.m; req1_addr = b.a; req1_wdata = b.d;
    endtask

    task automatic add(input req_t a, input req_t b, input out_t e);
        vec_t v;
        v.r0 = a;
        v.r1 = b;
        v.e  = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input out_t got, input out_t want);
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got rdy=%b%b we=%b m=%h a=%h din=%h r0=%b/%h r1=%b/%h ; want rdy=%b%b we=%b m=%h a=%h din=%h r0=%b/%h r1=%b/%h",
                     name, got.rdy0, got.rdy1, got.swe, got.smask, got.saddr, got.sdin,
                     got.rv0, got.rd0, got.rv1, got.rd1,
                     want.rdy0, want.rdy1, want.swe, want.smask, want.saddr, want.sdin,
                     want.rv0, want.rd0, want.rv1, want.rd1);
        end
    endtask

    out_t z;

    initial begin
        z = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = mv(i);
        for (int i = 0; i < int'(LAT); i++) dpipe[i] = '0;

        // Reset with a write pending: nothing may be granted or issued.
        reset = 1'b1;
        drive(wr_req(8'd3, 32'h1, 4'hF), no_req());
        #1;
        check("reset_outputs", sample(), z);
        @(negedge clock);
        drive(no_req(), no_req());
        reset = 1'b0;

        // Contended reads, alternating grants starting with port 0.
        add(rd_req(0), rd_req(1), exp_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(rd_req(2), rd_req(1), exp_out(0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        add(rd_req(2), rd_req(3), exp_out(1, 0, 0, 0, 2, 0, 1, mv(0), 0, 0));
        add(rd_req(4), rd_req(3), exp_out(0, 1, 0, 0, 3, 0, 0, 0, 1, mv(1)));
        add(rd_req(4), rd_req(5), exp_out(1, 0, 0, 0, 4, 0, 1, mv(2), 0, 0));
        add(rd_req(6), rd_req(5), exp_out(0, 1, 0, 0, 5, 0, 0, 0, 1, mv(3)));
        add(rd_req(6), no_req(),  exp_out(1, 0, 0, 0, 6, 0, 1, mv(4), 0, 0));
        add(no_req(),  no_req(),  exp_out(0, 0, 0, 0, 0, 0, 0, 0, 1, mv(5)));
        add(no_req(),  no_req(),  exp_out(0, 0, 0, 0, 0, 0, 1, mv(6), 0, 0));
        add(no_req(),  no_req(),  z);
        // Write then read back on port 0.
        add(wr_req(5, 32'd13, 4'hF), no_req(), exp_out(1, 0, 1, 4'hF, 5, 32'd13, 0, 0, 0, 0));
        add(rd_req(5), no_req(),  exp_out(1, 0, 0, 0, 5, 0, 0, 0, 0, 0));
        add(no_req(),  no_req(),  z);
        add(no_req(),  no_req(),  exp_out(0, 0, 0, 0, 0, 0, 1, 32'd13, 0, 0));
        // Partial-lane write, then four back-to-back port 1 reads.
        add(no_req(), wr_req(7, 32'hFFFF_FFFF, 4'hF),
            exp_out(0, 1, 1, 4'hF, 7, 32'hFFFF_FFFF, 0, 0, 0, 0));
        add(no_req(), wr_req(7, 32'h0, 4'b0101), exp_out(0, 1, 1, 4'b0101, 7, 0, 0, 0, 0, 0));
        add(no_req(), rd_req(7),  exp_out(0, 1, 0, 0, 7, 0, 0, 0, 0, 0));
        add(no_req(), rd_req(8),  exp_out(0, 1, 0, 0, 8, 0, 0, 0, 0, 0));
        add(no_req(), rd_req(9),  exp_out(0, 1, 0, 0, 9, 0, 0, 0, 1, 32'hFF00_FF00));
        add(no_req(), rd_req(10), exp_out(0, 1, 0, 0, 10, 0, 0, 0, 1, mv(8)));
        add(no_req(), no_req(),   exp_out(0, 0, 0, 0, 0, 0, 0, 0, 1, mv(9)));
        add(no_req(), no_req(),   exp_out(0, 0, 0, 0, 0, 0, 0, 0, 1, mv(10)));
        // Zero-mask write is granted but leaves memory unchanged.
        add(wr_req(9, 32'h1234_5678, 4'h0), no_req(),
            exp_out(1, 0, 1, 4'h0, 9, 32'h1234_5678, 0, 0, 0, 0));
        add(rd_req(9), no_req(),  exp_out(1, 0, 0, 0, 9, 0, 0, 0, 0, 0));
        add(no_req(),  no_req(),  z);
        add(no_req(),  no_req(),  exp_out(0, 0, 0, 0, 0, 0, 1, mv(9), 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            drive(vecs[i].r0, vecs[i].r1);
            #1;
            check($sformatf("vec%0d", i), sample(), vecs[i].e);
        end

        // Reset one cycle after a read grant: the read must never respond.
        @(negedge clock);
        drive(rd_req(3), no_req());
        #1;
        check("pre_reset_grant", sample(), exp_out(1, 0, 0, 0, 3, 0, 0, 0, 0, 0));
        @(negedge clock);
        reset = 1'b1;
        drive(rd_req(4), no_req());
        #1;
        check("reset_blocks_ready", sample(), z);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            #1;
            check($sformatf("reset_hold%0d", i), sample(), z);
        end
        @(negedge clock);
        reset = 1'b0;
        drive(no_req(), no_req());
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("post_reset_idle%0d", i), sample(), z);
            @(negedge clock);
        end
        // First contended grant after reset belongs to port 0.
        drive(rd_req(1), rd_req(2));
        #1;
        check("post_reset_contend", sample(), exp_out(1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        @(negedge clock);
        drive(no_req(), rd_req(2));
        #1;
        check("post_reset_p1", sample(), exp_out(0, 1, 0, 0, 2, 0, 0, 0, 0, 0));
        @(negedge clock);
        drive(no_req(), no_req());
        #1;
        check("post_reset_resp0", sample(), exp_out(0, 0, 0, 0, 0, 0, 1, mv(1), 0, 0));
        @(negedge clock);
        #1;
        check("post_reset_resp1", sample(), exp_out(0, 0, 0, 0, 0, 0, 0, 0, 1, mv(2)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
